// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Purpose  : Single-port data-memory responder. Accepts one load/store request
//            at a time over a valid/ready channel, waits WAIT_CYCLES cycles,
//            then commits the store (or captures the load word) and holds the
//            response until the initiator takes it.
//
// Ports    : clk        - clock, all state changes on the rising edge
//            rst        - asynchronous active-high reset
//            req_valid  - request present          req_ready - can accept
//            req_we     - 1 store / 0 load         req_addr  - byte address
//            req_wdata  - store data (LE lanes)    req_be    - byte enables
//            rsp_valid  - response present         rsp_ready - response taken
//            rsp_rdata  - load data (0 for stores and errors)
//            rsp_err    - misaligned request rejected
//
// Options  : DMEM_MISALIGN_CHECK_EN - when defined, a request whose addr[1:0]
//            is non-zero performs no write and returns rsp_err=1, rdata=0.
//            When undefined, addr[1:0] is ignored and rsp_err is always 0.
//
// Revision : 1.0 - initial release
// ============================================================================
module dmem_responder #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int         AW        = $clog2(DEPTH);
  // Counter preload: the handshake edge itself does not count as a wait cycle.
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [3:0]      be_q, be_d;
  logic            err_q, err_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [31:0]     rsp_rdata_q, rsp_rdata_d;
  logic            rsp_err_q, rsp_err_d;

  logic [31:0]     mem [DEPTH];

  logic            hs;
  logic            from_req;
  logic            acc_we;
  logic [AW-1:0]   acc_idx;
  logic [31:0]     acc_wdata;
  logic [3:0]      acc_be;
  logic            acc_err;
  logic            req_mis;
  logic            commit;
  logic            mem_we;
  logic [31:0]     mem_rd;
  logic [31:0]     merged;
  logic            unused_addr;

  assign req_ready = (state_q == S_IDLE) && !rst;
  assign hs        = req_valid && req_ready;

  // With zero wait cycles the access commits on the handshake edge, so the
  // access fields come straight from the request; otherwise from the latches.
  assign from_req  = (state_q == S_IDLE);
  assign acc_we    = from_req ? req_we            : we_q;
  assign acc_idx   = from_req ? req_addr[AW+1:2]  : idx_q;
  assign acc_wdata = from_req ? req_wdata         : wdata_q;
  assign acc_be    = from_req ? req_be            : be_q;
  assign acc_err   = from_req ? req_mis           : err_q;

`ifdef DMEM_MISALIGN_CHECK_EN
  assign req_mis = (req_addr[1:0] != 2'b00);
`else
  assign req_mis = 1'b0;
`endif

  // Upper address bits alias onto the array; low bits only matter for the
  // misalignment check.
  assign unused_addr = ^{req_addr[31:AW+2], req_addr[1:0]};

  assign commit = ((state_q == S_IDLE) && hs && (WAIT_CYCLES == 0)) ||
                  ((state_q == S_WAIT) && (cnt_q == 4'd0));
  assign mem_we = commit && acc_we && !acc_err && !rst;
  assign mem_rd = mem[acc_idx];

  always_comb begin
    merged = mem_rd;
    for (int i = 0; i < 4; i++) begin
      if (acc_be[i]) merged[8*i +: 8] = acc_wdata[8*i +: 8];
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    err_d       = err_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      S_IDLE: begin
        if (hs) begin
          we_d    = req_we;
          idx_d   = req_addr[AW+1:2];
          wdata_d = req_wdata;
          be_d    = req_be;
          err_d   = req_mis;
          if (WAIT_CYCLES != 0) begin
            state_d = S_WAIT;
            cnt_d   = WAIT_LOAD;
          end else begin
            state_d = S_RESP;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q != 4'd0) cnt_d   = cnt_q - 4'd1;
        else               state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
          rsp_rdata_d = 32'd0;
          rsp_err_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Response is loaded on the same edge that commits the access.
    if (commit) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = acc_err;
      rsp_rdata_d = (acc_we || acc_err) ? 32'd0 : mem_rd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      idx_q       <= '0;
      wdata_q     <= 32'd0;
      be_q        <= 4'd0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      err_q       <= err_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Storage is deliberately outside the reset domain: contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[acc_idx] <= merged;
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Purpose  : Self-checking bench for dmem_responder (DEPTH=256,
//            WAIT_CYCLES=1): directed vector table, reset corner sequences and
//            randomized traffic against a word-array reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

  localparam int DEPTH       = 256;
  localparam int WAIT_CYCLES = 1;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int tests_run;
  int tests_failed;

  logic [31:0] model_mem [DEPTH];

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          hold;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [11];

  dmem_responder #(
    .DEPTH       (DEPTH),
    .WAIT_CYCLES (WAIT_CYCLES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] prefill(input int i);
    logic [7:0] b;
    b = 8'(i);
    return {8'hC0, b, 8'h5A, ~b};
  endfunction

  // Reference: word array indexed by address modulo the storage size.
  task automatic model_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, output logic [31:0] exp_rd, output logic exp_err);
    int unsigned idx;
    logic        mis;
    idx = (addr / 4) % DEPTH;
    mis = 1'b0;
`ifdef DMEM_MISALIGN_CHECK_EN
    mis = (addr % 4) != 0;
`endif
    exp_err = mis;
    exp_rd  = 32'd0;
    if (!mis) begin
      if (we) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) model_mem[idx][8*b +: 8] = wdata[8*b +: 8];
      end else begin
        exp_rd = model_mem[idx];
      end
    end
  endtask

  // Issues one request from an IDLE cycle and checks latency, response hold
  // for `hold` cycles, and the return to IDLE after the response handshake.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input int hold,
                        input logic [31:0] exp_rd, input logic exp_err);
    int k;
    check("req_ready_before_req", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    @(negedge clk);
    // Garbage on the request bus must not disturb the access in flight.
    req_valid = 1'($urandom_range(0, 1));
    req_we    = 1'($urandom_range(0, 1));
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_be    = 4'($urandom_range(0, 15));
    k = 1;
    while (!rsp_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("rsp_latency", 32'(k), 32'(WAIT_CYCLES + 1));
    check("rsp_rdata", rsp_rdata, exp_rd);
    check("rsp_err", {31'd0, rsp_err}, {31'd0, exp_err});
    check("req_ready_in_resp", {31'd0, req_ready}, 32'd0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", {31'd0, rsp_valid}, 32'd1);
      check("hold_rdata", rsp_rdata, exp_rd);
      check("hold_err", {31'd0, rsp_err}, {31'd0, exp_err});
      check("hold_req_ready", {31'd0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("post_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("post_rsp_req_ready", {31'd0, req_ready}, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd0);
    check({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    check({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    check({tag, "_rsp_err"},   {31'd0, rsp_err}, 32'd0);
  endtask

  function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] be, input int hold,
                              input logic [31:0] exp_rdata, input logic exp_err);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.be = be;
    v.hold = hold; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    return v;
  endfunction

  initial begin
    logic [31:0] erd;
    logic        eerr;
    logic [31:0] a;

    tests_run    = 0;
    tests_failed = 0;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 32'd0;
    req_wdata = 32'd0;
    req_be    = 4'd0;
    rsp_ready = 1'b0;

    vecs[0]  = mk(1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 0, 32'h0,        1'b0);
    vecs[1]  = mk(1'b0, 32'h10,  32'h0,        4'h0, 5, 32'hDEADBEEF, 1'b0);
    vecs[2]  = mk(1'b1, 32'h20,  32'h11223344, 4'hF, 1, 32'h0,        1'b0);
    vecs[3]  = mk(1'b1, 32'h20,  32'hAABBCCDD, 4'h5, 0, 32'h0,        1'b0);
    vecs[4]  = mk(1'b0, 32'h20,  32'h0,        4'h0, 2, 32'h11BB33DD, 1'b0);
    vecs[5]  = mk(1'b1, 32'h400, 32'h5,        4'hF, 0, 32'h0,        1'b0);
    vecs[6]  = mk(1'b0, 32'h0,   32'h0,        4'h0, 0, 32'h5,        1'b0);
    vecs[7]  = mk(1'b1, 32'h44,  32'h12345678, 4'h0, 0, 32'h0,        1'b0);
    vecs[8]  = mk(1'b0, 32'h44,  32'h0,        4'h0, 0, prefill(17),  1'b0);
`ifdef DMEM_MISALIGN_CHECK_EN
    vecs[9]  = mk(1'b1, 32'h42,  32'hCAFEF00D, 4'hF, 0, 32'h0,        1'b1);
    vecs[10] = mk(1'b0, 32'h40,  32'h0,        4'h0, 0, prefill(16),  1'b0);
`else
    vecs[9]  = mk(1'b1, 32'h42,  32'hCAFEF00D, 4'hF, 0, 32'h0,        1'b0);
    vecs[10] = mk(1'b0, 32'h40,  32'h0,        4'h0, 0, 32'hCAFEF00D, 1'b0);
`endif

    // Reset state, then ready in the first cycle after release.
    @(negedge clk);
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("ready_after_reset", {31'd0, req_ready}, 32'd1);

    // Give every word a known value.
    for (int i = 0; i < DEPTH; i++) begin
      model_op(1'b1, 32'(i * 4), prefill(i), 4'hF, erd, eerr);
      do_req(1'b1, 32'(i * 4), prefill(i), 4'hF, 0, erd, eerr);
    end

    // Directed vectors.
    for (int v = 0; v < 11; v++) begin
      model_op(vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].be, erd, eerr);
      do_req(vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].be, vecs[v].hold,
             vecs[v].exp_rdata, vecs[v].exp_err);
    end

    // Reset during WAIT aborts the store to 0x30.
    model_op(1'b1, 32'h30, 32'h0, 4'hF, erd, eerr);
    do_req(1'b1, 32'h30, 32'h0, 4'hF, 0, erd, eerr);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h30;
    req_wdata = 32'hFFFFFFFF; req_be = 4'hF;
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_in_wait");
    @(negedge clk);
    check_reset_outputs("rst_in_wait_edge");
    rst = 1'b0;
    #1;
    check("ready_after_wait_abort", {31'd0, req_ready}, 32'd1);
    do_req(1'b0, 32'h30, 32'h0, 4'h0, 0, 32'h0, 1'b0);

    // Reset during RESP drops the response but keeps the committed store.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h34;
    req_wdata = 32'h600DF00D; req_be = 4'hF;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("resp_before_reset", {31'd0, rsp_valid}, 32'd1);
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_in_resp");
    @(negedge clk);
    rst = 1'b0;
    #1;
    model_op(1'b1, 32'h34, 32'h600DF00D, 4'hF, erd, eerr);
    do_req(1'b0, 32'h34, 32'h0, 4'h0, 0, 32'h600DF00D, 1'b0);

    // Randomized traffic against the reference model.
    for (int t = 0; t < 200; t++) begin
      logic        we;
      logic [31:0] wd;
      logic [3:0]  be;
      int          hold;
      we   = 1'($urandom_range(0, 1));
      a    = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      wd   = $urandom;
      be   = 4'($urandom_range(0, 15));
      hold = $urandom_range(0, 3);
      model_op(we, a, wd, be, erd, eerr);
      do_req(we, a, wd, be, hold, erd, eerr);
      for (int g = $urandom_range(0, 2); g > 0; g--) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH, 256, number of 32-bit words in storage; power of two, 4..4096.
REQ-002 Parameter WAIT_CYCLES, 1, extra access latency cycles; 0..15.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req_valid  input  1  initiator presents a load/store request.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data, little-endian lanes.
REQ-010 req_be  input  4  store byte enables; bit i selects wdata[8i+7:8i].
REQ-011 rsp_valid  output  1  response available.
REQ-012 rsp_ready  input  1  initiator accepts response.
REQ-013 rsp_rdata  output  32  load data.
REQ-014 rsp_err  output  1  request rejected; see Configuration.

Function
REQ-015 FSM states IDLE, WAIT, RESP; req_ready SHALL be 1 only in IDLE with rst low.
REQ-016 Request handshake = req_valid & req_ready in cycle N; responder SHALL latch we, addr, wdata, be at that edge.
REQ-017 IDLE->WAIT on handshake if WAIT_CYCLES>0; otherwise IDLE->RESP.
REQ-018 WAIT SHALL count WAIT_CYCLES cycles with a down-counter, then enter RESP.
REQ-019 Store commit and load capture SHALL occur on the edge entering RESP; rsp_valid SHALL rise in cycle N+1+WAIT_CYCLES.
REQ-020 Word index = addr[log2(DEPTH)+1:2]; higher address bits ignored (aliasing wrap-around).
REQ-021 Store SHALL update only lanes with be set; be=4'b0000 store SHALL leave memory unchanged yet still respond.
REQ-022 Load SHALL return the full word; rsp_rdata SHALL be 0 for store responses.
REQ-023 In RESP, rsp_valid, rsp_rdata, rsp_err SHALL hold stable until rsp_valid & rsp_ready.
REQ-024 Response handshake SHALL return FSM to IDLE; next request accepted earliest the following cycle (throughput one per WAIT_CYCLES+2 cycles).
REQ-025 req_* inputs SHALL be ignored outside IDLE; changes after handshake SHALL not affect the access in flight.
REQ-026 Load from an address after a completed store to it SHALL return the merged new data.

Reset
REQ-027 While rst high: state IDLE, req_ready 0, rsp_valid 0, rsp_rdata 0, rsp_err 0, wait counter 0.
REQ-028 Reset in WAIT SHALL abort the access; the uncommitted store SHALL NOT modify memory.
REQ-029 Reset in RESP SHALL drop the pending response; an already committed store remains.
REQ-030 Memory contents SHALL NOT be cleared by reset.
REQ-031 req_ready SHALL go to 1 in the first cycle after rst deasserts.

Configuration
REQ-032 Macro DMEM_MISALIGN_CHECK_EN defined: request with addr[1:0] != 0 SHALL perform no write, respond with same latency, rsp_err 1, rsp_rdata 0.
REQ-033 Macro DMEM_MISALIGN_CHECK_EN undefined: addr[1:0] ignored, access proceeds on aligned word, rsp_err tied 0.

Verification
REQ-034 WAIT_CYCLES=1: store addr 0x10, wdata 0xDEADBEEF, be 4'hF at cycle N -> rsp_valid at N+2, rdata 0; load 0x10 returns 0xDEADBEEF.
REQ-035 Word 0x20 = 0x11223344; store be 4'b0101, wdata 0xAABBCCDD -> later load returns 0x11BB33DD.
REQ-036 Hold rsp_ready low 5 cycles in RESP -> rsp_valid and rdata stable, req_ready 0 throughout; accept on cycle 6 -> IDLE next cycle.
REQ-037 DEPTH=256: store 0x0000_0400 data 0x5 -> load 0x0 returns 0x5 (wrap).
REQ-038 Assert rst during WAIT of store to 0x30 (old 0x0) -> outputs reset, load 0x30 returns 0x0.
REQ-039 With DMEM_MISALIGN_CHECK_EN, store to 0x42 -> rsp_err 1, word 0x40 unchanged; without macro -> word 0x40 written, rsp_err 0.
